// File: rtl/common.sv
// Shared cbus types used by the core-side masters and the address-translation unit.
package common;

    typedef logic [63:0] u64;

    typedef enum logic [1:0] {SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B} cbus_size_e;
    typedef enum logic [1:0] {LEN_1, LEN_2, LEN_4, LEN_8} cbus_len_e;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        we;
        u64          addr;
        u64          wdata;
        cbus_size_e  size;
        cbus_len_e   len;
        cbus_burst_e burst;
    } cbus_req_t;

    typedef struct packed {
        logic ready;
        logic last;
        u64   data;
    } cbus_resp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i searching prio_i, prio_i+1, ... mod N.
module rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] prio_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    int cand;

    always_comb begin
        any_o = |valid_i;
        idx_o = prio_i;
        cand  = 0;
        // Walk from the farthest offset down so the closest match to prio_i wins.
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(prio_i) + k) % N;
            if (valid_i[cand]) begin
                idx_o = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Shares the translation unit's single cbus port between N requesters, holding each grant
// until resp_in.ready && last so multi-step page walks keep seeing the owner's address.
module cbus_rr_arbiter
    import common::*;
#(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  cbus_req_t            req_in   [N],
    output cbus_resp_t           resp_out [N],
    output cbus_req_t            req_out,
    input  cbus_resp_t           resp_in,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q;
    logic [IW-1:0]   prio_q;
    logic [IW-1:0]   owner_q;
    logic [N-1:0]    req_vld;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            done;
    logic [IW-1:0]   owner_inc;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_vld[i] = req_in[i].valid;
        end
    end

    rr_pick #(.N(N)) u_pick (
        .valid_i (req_vld),
        .prio_i  (prio_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    assign done      = (state_q == BUSY) && resp_in.ready && resp_in.last;
    assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

    // Completion always returns to IDLE, so the next grant sees the updated prio
    // and valid is guaranteed low downstream for at least one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        prio_q  <= owner_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == BUSY);
    assign owner = owner_q;

    always_comb begin
        req_out = '0;
        if (state_q == BUSY) begin
            req_out       = req_in[owner_q];
            req_out.valid = 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            resp_out[j] = '0;
            if ((state_q == BUSY) && (owner_q == IW'(j))) begin
                resp_out[j] = resp_in;
            end
        end
    end

endmodule
